// File: rtl/stream_mux_arb_pkg.sv
// Shared constants and helpers for the stream_mux_arb slice: mode encodings
// and a minimum-1 ceiling-log2 used to size channel indices.
package stream_mux_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2_min1(input int n);
    int r;
    r = 32'sd0;
    for (int i = 32'sd0; i < 32'sd31; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 32'sd1;
      end
    end
    return (r < 32'sd1) ? 32'sd1 : r;
  endfunction

endpackage

// File: rtl/stream_mux_arb_rr_pick.sv
// Round-robin picker: returns the first requesting channel after base,
// scanning base+1, base+2, ... modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] base,
  output logic [SW-1:0] gnt,
  output logic          gnt_vld
);

  // Smallest circular distance from base wins; distance 0 is base+1.
  always_comb begin
    int   d_s;
    int   best_s;
    logic take_s;
    d_s     = 32'sd0;
    best_s  = N;
    take_s  = 1'b0;
    gnt     = '0;
    for (int c = 0; c < N; c++) begin
      d_s    = (c > int'(base)) ? (c - int'(base) - 32'sd1)
                                : (c + N - int'(base) - 32'sd1);
      take_s = req[c] && (d_s < best_s);
      best_s = take_s ? d_s : best_s;
      gnt    = take_s ? SW'(c) : gnt;
    end
    gnt_vld = |req;
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-to-1 valid/ready stream mux with one registered output stage, fixed or
// round-robin selection. Packet lock is built only with STREAM_MUX_LOCK_EN.
module stream_mux_arb
  import stream_mux_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int SW = clog2_min1(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SW-1:0]   s,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  input  logic            out_ready
`ifdef STREAM_MUX_LOCK_EN
  ,
  input  logic [N-1:0]    in_last,
  output logic            out_last
`endif
);

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic [W-1:0]  ch_data_s [N];
  logic          load_s;
  logic          lock_s;
  logic [SW-1:0] gnt_s;
  logic          gnt_vld_s;
  logic [SW-1:0] rr_gnt_s;
  logic          rr_vld_s;
  logic          out_valid_r;
  logic [W-1:0]  out_data_r;
  logic [SW-1:0] out_ch_r;
  logic [SW-1:0] rr_ptr_r;

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch_data_s[i] = in_data[i*W +: W];
  end

  rr_pick #(.N(N), .SW(SW)) u_rr_pick (
    .req     (in_valid),
    .base    (rr_ptr_r),
    .gnt     (rr_gnt_s),
    .gnt_vld (rr_vld_s)
  );

  assign load_s = ~out_valid_r | out_ready;

  // Grant source: a locked packet owns the mux, otherwise mode decides.
  // Shifting a one-hot by s>=N yields zero, so out-of-range s never grants.
  always_comb begin
    gnt_s     = rr_gnt_s;
    gnt_vld_s = rr_vld_s;
    if (lock_s) begin
      gnt_s     = out_ch_r;
      gnt_vld_s = |(in_valid & (ONE_HOT0 << out_ch_r));
    end else begin
      case (mode)
        MODE_FIXED: begin
          gnt_s     = s;
          gnt_vld_s = |(in_valid & (ONE_HOT0 << s));
        end
        MODE_RR: begin
          gnt_s     = rr_gnt_s;
          gnt_vld_s = rr_vld_s;
        end
        default: begin
          gnt_s     = '0;
          gnt_vld_s = 1'b0;
        end
      endcase
    end
  end

  assign in_ready = {N{load_s & gnt_vld_s & ~rst}} & (ONE_HOT0 << gnt_s);

  // Output stage and round-robin pointer; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
      rr_ptr_r    <= SW'(N - 1);
    end else if (load_s) begin
      if (gnt_vld_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= ch_data_s[gnt_s];
        out_ch_r    <= gnt_s;
        rr_ptr_r    <= gnt_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;

`ifdef STREAM_MUX_LOCK_EN
  logic lock_r;
  logic out_last_r;
  logic last_s;

  assign last_s = |(in_last & (ONE_HOT0 << gnt_s));

  // Lock engages after any non-final word and releases on the final one.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_r     <= 1'b0;
      out_last_r <= 1'b0;
    end else if (load_s && gnt_vld_s) begin
      lock_r     <= ~last_s;
      out_last_r <= last_s;
    end
  end

  assign lock_s   = lock_r;
  assign out_last = out_last_r;
`else
  assign lock_s = 1'b0;
`endif

endmodule
